// File: rtl/iotdf_seq_ctrl_if.sv
// iotdf_seq_ctrl_if
// Bundles the host byte interface and the datapath word handshake of the
// IOTDF front-end sequencer.
//   Host side : in_en, iot_in, fn_sel (to sequencer), busy (from sequencer)
//   Datapath  : dp_word, dp_vld, dp_first, dp_last, dp_fn (from sequencer),
//               dp_ack, dp_done (to sequencer)
// Modports:
//   slave  - the sequencer itself
//   master - the environment around it (host plus datapath)
interface iotdf_seq_ctrl_if #(
    parameter int BYTES_PER_WORD = 16
);
    logic                          in_en;
    logic [7:0]                    iot_in;
    logic [3:0]                    fn_sel;
    logic                          busy;
    logic [8*BYTES_PER_WORD-1:0]   dp_word;
    logic                          dp_vld;
    logic                          dp_first;
    logic                          dp_last;
    logic [3:0]                    dp_fn;
    logic                          dp_ack;
    logic                          dp_done;

    modport slave (
        input  in_en, iot_in, fn_sel, dp_ack, dp_done,
        output busy, dp_word, dp_vld, dp_first, dp_last, dp_fn
    );

    modport master (
        output in_en, iot_in, fn_sel, dp_ack, dp_done,
        input  busy, dp_word, dp_vld, dp_first, dp_last, dp_fn
    );
endinterface

// File: rtl/iotdf_seq_ctrl.sv
// iotdf_seq_ctrl
// Front-end sequencer for the IOTDF filter datapath. Packs host bytes into
// words (first byte lands in the least significant byte), groups words into
// rounds, latches the function select at round start and hands each word to
// the datapath with a valid/ack handshake tagged first/last. busy tells the
// host its bytes are being dropped while a word waits for acceptance or the
// round result is still being computed.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active low
//   bus       - host + datapath signals (iotdf_seq_ctrl_if.slave)
//   round_cnt - number of completed rounds, wraps at 128
// Every output comes straight from a flop.
module iotdf_seq_ctrl #(
    parameter int BYTES_PER_WORD  = 16,
    parameter int WORDS_PER_ROUND = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    iotdf_seq_ctrl_if.slave      bus,
    output logic [6:0]           round_cnt
);
    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int BC_W   = $clog2(BYTES_PER_WORD);
    localparam int WI_W   = $clog2(WORDS_PER_ROUND);
    localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [WI_W-1:0] WORD_LAST = WI_W'(WORDS_PER_ROUND - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_r,     state_s;
    logic [BC_W-1:0]     byte_cnt_r,  byte_cnt_s;
    logic [WI_W-1:0]     word_idx_r,  word_idx_s;
    logic [WORD_W-1:0]   word_r,      word_s;
    logic [3:0]          fn_r,        fn_s;
    logic                busy_r,      busy_s;
    logic                vld_r,       vld_s;
    logic                first_r,     first_s;
    logic                last_r,      last_s;
    logic [6:0]          round_cnt_r, round_cnt_s;

    assign bus.busy     = busy_r;
    assign bus.dp_word  = word_r;
    assign bus.dp_vld   = vld_r;
    assign bus.dp_first = first_r;
    assign bus.dp_last  = last_r;
    assign bus.dp_fn    = fn_r;
    assign round_cnt    = round_cnt_r;

    // Next-state and next-output logic; busy/vld/first/last are computed
    // one edge ahead so they come out of flops.
    always_comb begin
        state_s     = state_r;
        byte_cnt_s  = byte_cnt_r;
        word_idx_s  = word_idx_r;
        word_s      = word_r;
        fn_s        = fn_r;
        busy_s      = busy_r;
        vld_s       = vld_r;
        first_s     = first_r;
        last_s      = last_r;
        round_cnt_s = round_cnt_r;

        case (state_r)
            IDLE: begin
                if (bus.in_en) begin
                    word_s[7:0] = bus.iot_in;
                    fn_s        = bus.fn_sel;
                    byte_cnt_s  = BC_W'(1);
                    state_s     = FILL;
                end else begin
                    state_s = IDLE;
                end
            end

            FILL: begin
                if (bus.in_en) begin
                    word_s[{byte_cnt_r, 3'b000} +: 8] = bus.iot_in;
                    byte_cnt_s = byte_cnt_r + BC_W'(1);
                    if (byte_cnt_r == BYTE_LAST) begin
                        // Tags are decided here, on ISSUE entry only.
                        state_s    = ISSUE;
                        busy_s     = 1'b1;
                        vld_s      = 1'b1;
                        first_s    = (word_idx_r == {WI_W{1'b0}});
                        last_s     = (word_idx_r == WORD_LAST);
                        byte_cnt_s = {BC_W{1'b0}};
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end

            ISSUE: begin
                if (bus.dp_ack) begin
                    vld_s = 1'b0;
                    if (word_idx_r == WORD_LAST) begin
                        // A done arriving with the last ack closes the round at once.
                        if (bus.dp_done) begin
                            state_s     = IDLE;
                            busy_s      = 1'b0;
                            word_idx_s  = {WI_W{1'b0}};
                            round_cnt_s = round_cnt_r + 7'd1;
                        end else begin
                            state_s = DRAIN;
                        end
                    end else begin
                        state_s    = FILL;
                        busy_s     = 1'b0;
                        byte_cnt_s = {BC_W{1'b0}};
                        word_idx_s = word_idx_r + WI_W'(1);
                    end
                end else begin
                    state_s = ISSUE;
                end
            end

            DRAIN: begin
                if (bus.dp_done) begin
                    state_s     = IDLE;
                    busy_s      = 1'b0;
                    word_idx_s  = {WI_W{1'b0}};
                    round_cnt_s = round_cnt_r + 7'd1;
                end else begin
                    state_s = DRAIN;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial word or round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            byte_cnt_r  <= {BC_W{1'b0}};
            word_idx_r  <= {WI_W{1'b0}};
            word_r      <= {WORD_W{1'b0}};
            fn_r        <= 4'd0;
            busy_r      <= 1'b0;
            vld_r       <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            round_cnt_r <= 7'd0;
        end else begin
            state_r     <= state_s;
            byte_cnt_r  <= byte_cnt_s;
            word_idx_r  <= word_idx_s;
            word_r      <= word_s;
            fn_r        <= fn_s;
            busy_r      <= busy_s;
            vld_r       <= vld_s;
            first_r     <= first_s;
            last_r      <= last_s;
            round_cnt_r <= round_cnt_s;
        end
    end
endmodule

// File: tb/tb_iotdf_seq_ctrl.sv
// Directed self-checking bench for iotdf_seq_ctrl.
module tb_iotdf_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] round_cnt;
    int         checks   = 0;
    int         failures = 0;

    iotdf_seq_ctrl_if #(.BYTES_PER_WORD(16)) bus ();

    iotdf_seq_ctrl #(.BYTES_PER_WORD(16), .WORDS_PER_ROUND(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .round_cnt (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_en  = 1'b1;
        bus.iot_in = b;
        step();
        bus.in_en  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] base);
        for (int j = 0; j < 16; j++) send_byte(base + 8'(j));
    endtask

    function automatic logic [127:0] mk_word(input logic [7:0] base);
        logic [127:0] w;
        w = 128'd0;
        for (int j = 0; j < 16; j++) w[8*j +: 8] = base + 8'(j);
        return w;
    endfunction

    task automatic do_reset();
        rst         = 1'b0;
        bus.in_en   = 1'b0;
        bus.iot_in  = 8'h00;
        bus.fn_sel  = 4'd0;
        bus.dp_ack  = 1'b0;
        bus.dp_done = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.in_en   = 1'b0;
        bus.iot_in  = 8'h00;
        bus.fn_sel  = 4'd0;
        bus.dp_ack  = 1'b0;
        bus.dp_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last}, 4'b0000);
        end
        checks++;
        if (bus.dp_word !== 128'd0 || bus.dp_fn !== 4'd0 || round_cnt !== 7'd0) begin
            failures++;
            $display("FAIL reset_values got word=%h fn=%h rc=%0d exp 0/0/0", bus.dp_word, bus.dp_fn, round_cnt);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_single_word();
        logic [127:0] exp_w;
        int           busy_cycles;
        exp_w = 128'h0F0E0D0C0B0A09080706050403020100;
        do_reset();
        bus.dp_ack = 1'b1;
        send_word(8'h00);
        checks++;
        if ({bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last} !== 4'b1110) begin
            failures++;
            $display("FAIL single_flags got=%b exp=%b", {bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last}, 4'b1110);
        end
        checks++;
        if (bus.dp_word !== exp_w) begin
            failures++;
            $display("FAIL single_word got=%h exp=%h", bus.dp_word, exp_w);
        end
        busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles !== 1) begin
            failures++;
            $display("FAIL single_busy_cycles got=%0d exp=%0d", busy_cycles, 1);
        end
        checks++;
        if (bus.dp_vld !== 1'b0) begin
            failures++;
            $display("FAIL single_vld_after_ack got=%b exp=%b", bus.dp_vld, 1'b0);
        end
    endtask

    task automatic test_stalled_input();
        logic [127:0] exp_w;
        int           gap;
        exp_w = 128'h0F0E0D0C0B0A09080706050403020100;
        do_reset();
        bus.dp_ack = 1'b1;
        for (int j = 0; j < 16; j++) begin
            send_byte(8'(j));
            checks++;
            if (bus.dp_vld !== (j == 15)) begin
                failures++;
                $display("FAIL stall_vld_byte%0d got=%b exp=%b", j, bus.dp_vld, (j == 15));
            end
            gap = (j == 3) ? 1 : (j == 7) ? 2 : (j == 14) ? 3 : 0;
            for (int g = 0; g < gap; g++) begin
                step();
                checks++;
                if (bus.dp_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_vld_gap%0d got=%b exp=%b", j, bus.dp_vld, 1'b0);
                end
            end
        end
        checks++;
        if (bus.dp_word !== exp_w) begin
            failures++;
            $display("FAIL stall_word got=%h exp=%h", bus.dp_word, exp_w);
        end
        step();
    endtask

    task automatic test_back_pressure();
        logic [127:0] exp_w;
        do_reset();
        exp_w = mk_word(8'h10);
        send_word(8'h10);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                bus.in_en  = 1'b1;
                bus.iot_in = 8'hAA;
                step();
            end
            checks++;
            if ({bus.busy, bus.dp_vld} !== 2'b11 || bus.dp_word !== exp_w) begin
                failures++;
                $display("FAIL bp_hold_c%0d got busy/vld=%b word=%h exp 11 %h", c, {bus.busy, bus.dp_vld}, bus.dp_word, exp_w);
            end
        end
        bus.in_en  = 1'b0;
        bus.dp_ack = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.dp_vld} !== 2'b00) begin
            failures++;
            $display("FAIL bp_release got=%b exp=%b", {bus.busy, bus.dp_vld}, 2'b00);
        end
        exp_w = mk_word(8'h20);
        send_word(8'h20);
        checks++;
        if (bus.dp_word !== exp_w || {bus.dp_first, bus.dp_last} !== 2'b00) begin
            failures++;
            $display("FAIL bp_next_word got=%h f/l=%b exp=%h 00", bus.dp_word, {bus.dp_first, bus.dp_last}, exp_w);
        end
        step();
    endtask

    task automatic test_full_round();
        logic [127:0] exp_w;
        do_reset();
        bus.fn_sel = 4'd4;
        bus.dp_ack = 1'b1;
        for (int w = 0; w < 8; w++) begin
            exp_w = mk_word(8'(w * 16));
            send_word(8'(w * 16));
            checks++;
            if (bus.dp_fn !== 4'd4 || bus.dp_word !== exp_w ||
                {bus.dp_first, bus.dp_last} !== {(w == 0), (w == 7)}) begin
                failures++;
                $display("FAIL round_word%0d got fn=%0d f/l=%b word=%h exp fn=4 f/l=%b word=%h",
                         w, bus.dp_fn, {bus.dp_first, bus.dp_last}, bus.dp_word, {(w == 0), (w == 7)}, exp_w);
            end
            if (w == 2) bus.fn_sel = 4'd7;
            step();
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({bus.busy, bus.dp_vld} !== 2'b10 || round_cnt !== 7'd0) begin
                failures++;
                $display("FAIL round_drain%0d got busy/vld=%b rc=%0d exp 10 0", d, {bus.busy, bus.dp_vld}, round_cnt);
            end
            if (d == 2) bus.dp_done = 1'b1;
            step();
        end
        bus.dp_done = 1'b0;
        checks++;
        if ({bus.busy, bus.dp_vld} !== 2'b00 || round_cnt !== 7'd1) begin
            failures++;
            $display("FAIL round_end got busy/vld=%b rc=%0d exp 00 1", {bus.busy, bus.dp_vld}, round_cnt);
        end
        send_word(8'h80);
        checks++;
        if (bus.dp_fn !== 4'd7 || bus.dp_first !== 1'b1) begin
            failures++;
            $display("FAIL round_next_fn got fn=%0d first=%b exp fn=7 first=1", bus.dp_fn, bus.dp_first);
        end
        step();
    endtask

    task automatic test_done_with_last_ack();
        do_reset();
        bus.fn_sel  = 4'd2;
        bus.dp_ack  = 1'b1;
        bus.dp_done = 1'b1;
        for (int w = 0; w < 7; w++) begin
            send_word(8'(w * 16));
            step();
        end
        bus.dp_ack = 1'b0;
        send_word(8'h70);
        checks++;
        if ({bus.dp_vld, bus.dp_last} !== 2'b11 || round_cnt !== 7'd0) begin
            failures++;
            $display("FAIL donack_last got vld/last=%b rc=%0d exp 11 0", {bus.dp_vld, bus.dp_last}, round_cnt);
        end
        bus.dp_ack = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.dp_vld} !== 2'b00 || round_cnt !== 7'd1) begin
            failures++;
            $display("FAIL donack_idle got busy/vld=%b rc=%0d exp 00 1", {bus.busy, bus.dp_vld}, round_cnt);
        end
        step();
        checks++;
        if (round_cnt !== 7'd1) begin
            failures++;
            $display("FAIL donack_idle_done got rc=%0d exp 1", round_cnt);
        end
        bus.dp_done = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [127:0] exp_w;
        bus.fn_sel = 4'd5;
        bus.dp_ack = 1'b1;
        for (int w = 0; w < 3; w++) begin
            send_word(8'(w * 16));
            step();
        end
        for (int j = 0; j < 10; j++) send_byte(8'h50 + 8'(j));
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last} !== 4'b0000 ||
            bus.dp_word !== 128'd0 || bus.dp_fn !== 4'd0 || round_cnt !== 7'd0) begin
            failures++;
            $display("FAIL midrst_outputs got flags=%b word=%h fn=%0d rc=%0d exp 0000 0 0 0",
                     {bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last}, bus.dp_word, bus.dp_fn, round_cnt);
        end
        step();
        rst = 1'b1;
        bus.fn_sel = 4'd9;
        exp_w = mk_word(8'h30);
        send_word(8'h30);
        checks++;
        if ({bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last} !== 4'b1110 ||
            bus.dp_fn !== 4'd9 || bus.dp_word !== exp_w) begin
            failures++;
            $display("FAIL midrst_next got flags=%b fn=%0d word=%h exp 1110 9 %h",
                     {bus.busy, bus.dp_vld, bus.dp_first, bus.dp_last}, bus.dp_fn, bus.dp_word, exp_w);
        end
        step();
    endtask

    task automatic test_round_wrap();
        do_reset();
        bus.fn_sel  = 4'd1;
        bus.dp_ack  = 1'b1;
        bus.dp_done = 1'b1;
        for (int r = 0; r < 128; r++) begin
            for (int w = 0; w < 8; w++) begin
                send_word(8'(r));
                step();
            end
            if (r == 0) begin
                checks++;
                if (round_cnt !== 7'd1) begin
                    failures++;
                    $display("FAIL wrap_first got rc=%0d exp 1", round_cnt);
                end
            end
            if (r == 126) begin
                checks++;
                if (round_cnt !== 7'd127) begin
                    failures++;
                    $display("FAIL wrap_127 got rc=%0d exp 127", round_cnt);
                end
            end
        end
        checks++;
        if (round_cnt !== 7'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_zero got rc=%0d busy=%b exp 0 0", round_cnt, bus.busy);
        end
        bus.dp_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stalled_input();
        test_back_pressure();
        test_full_round();
        test_done_with_last_ack();
        test_reset_mid_word();
        test_round_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iotdf_seq_ctrl.md
# iotdf_seq_ctrl

Front-end sequencer for the IOTDF filter datapath. It assembles the host's 8-bit `iot_in` byte stream into 128-bit words and groups the words into rounds. It latches the function select once per round, presents each word to the datapath with a valid/ack handshake and first/last tags, and drives `busy` back-pressure to the host while a word is pending or a round result is being computed. It sits between the host interface (`in_en`/`iot_in`/`fn_sel`/`busy`) and the function datapath that produces `valid`/`iot_out`.

## Interface
- `BYTES_PER_WORD`, default 16: bytes per assembled word. The word width is `8*BYTES_PER_WORD`.
- `WORDS_PER_ROUND`, default 8: words per round; must be ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `in_en` in 1: host byte strobe.
- `iot_in` in 8: host data byte.
- `fn_sel` in 4: function select; sampled only at round start.
- `busy` out 1: registered; 1 means host bytes are ignored.
- `dp_word` out 128: assembled word. Byte j occupies bits [8j+7:8j]; the first byte received is byte 0.
- `dp_vld` out 1: `dp_word` is valid and waiting for acceptance.
- `dp_first` out 1: the current word is word 0 of the round (meaningful only while `dp_vld`=1).
- `dp_last` out 1: the current word is word `WORDS_PER_ROUND`-1 (meaningful only while `dp_vld`=1).
- `dp_fn` out 4: function select latched for the current round.
- `dp_ack` in 1: datapath accepts `dp_word` in this cycle.
- `dp_done` in 1: datapath has finished the round result.
- `round_cnt` out 7: completed rounds; wraps from 127 to 0.

## Operation
- States: IDLE, FILL, ISSUE, DRAIN. Counters: `byte_cnt` [3:0], `word_idx` [2:0].
- **IDLE** (`busy`=0):
  - On `in_en`=1: capture the byte into byte 0, latch `fn_sel` into `dp_fn`, set `byte_cnt`=1, go to FILL.
- **FILL** (`busy`=0):
  - On `in_en`=1: write `iot_in` into byte `byte_cnt` and increment `byte_cnt`.
  - On `in_en`=0: hold; gaps of any length are allowed.
  - On the edge that captures byte 15: go to ISSUE and set `busy`=1.
- **ISSUE** (`busy`=1, `dp_vld`=1, `dp_word` stable):
  - On `dp_ack`=1 with `word_idx` < last: increment `word_idx`, clear `byte_cnt`, go to FILL.
  - On `dp_ack`=1 with `word_idx` = last: go to DRAIN.
  - On `dp_ack`=1 with `word_idx` = last and `dp_done`=1 in the same cycle: go to IDLE directly, increment `round_cnt`, clear `word_idx`.
- **DRAIN** (`busy`=1, `dp_vld`=0):
  - On `dp_done`=1: go to IDLE, increment `round_cnt`, clear `word_idx`.
- Rules that apply in every state:
  - `in_en` while `busy`=1 is dropped. The byte is not stored and no counter changes.
  - `fn_sel` changes after round start do not affect `dp_fn` until the next IDLE→FILL transition.
  - `dp_ack` outside ISSUE is ignored. `dp_done` outside DRAIN is ignored, except in the ISSUE-last case above.
- Reset (asynchronous, at any time, including mid-word or mid-round):
  - All outputs and state return to reset values.
  - A partial word is discarded; the next accepted byte is byte 0 of word 0 of a new round.

## Timing
- Reset values: `busy`=0, `dp_vld`=0, `dp_first`=0, `dp_last`=0, `dp_word`=0, `dp_fn`=0, `round_cnt`=0, state IDLE.
- Byte 15 captured at edge N:
  - `dp_vld`=1 and `busy`=1 from edge N.
  - With `dp_ack`=1 in cycle N+1, `busy` falls at edge N+1.
  - Minimum word period is 17 cycles.
- `dp_first` and `dp_last` are registered alongside `dp_vld` and change only on ISSUE entry.
- Round end: `round_cnt` updates on the same edge that returns the block to IDLE; `busy` falls on that edge.
- Minimum round length is 8×17 cycles plus the DRAIN cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset check: assert `rst`=0 mid-simulation → all outputs at their reset values within the same cycle, before the next edge.
- Single word:
  - Stimulus: bytes 0x00…0x0F on 16 consecutive cycles, `dp_ack` tied 1.
  - Response: `dp_word`=0x0F0E0D0C0B0A09080706050403020100, `dp_first`=1, `dp_last`=0.
  - `busy`=1 for exactly 1 cycle.
- Stalled input:
  - Stimulus: same bytes with `in_en`=0 gaps of 1–3 cycles after bytes 3, 7 and 14.
  - Response: identical `dp_word`; `dp_vld` rises only after byte 0x0F.
- Back-pressure:
  - Stimulus: `dp_ack`=0 for 5 cycles, with `in_en`=1 bytes 0xAA driven meanwhile.
  - Response: `dp_vld` and `dp_word` stable for 6 cycles; 0xAA bytes are not present in the next word.
- Full round with `fn_sel` change:
  - Stimulus: `fn_sel`=4 at round start, changed to 7 after word 2; `dp_done` pulsed 3 cycles after the last ack.
  - Response: `dp_fn`=4 for all 8 words; `dp_last`=1 only on word 7; `busy`=1 throughout DRAIN; `round_cnt`=1.
  - Next round: `dp_fn`=7.
- Boundary cases:
  - `dp_done` together with the last `dp_ack` → IDLE on that edge with `round_cnt`+1.
  - `rst` at byte 9 of word 3 → the next word is issued with `dp_first`=1.
  - After 128 completed rounds → `round_cnt`=0.
